// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

    // Instruction operation select as presented on the op port
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int          MULDIV_ITER = 32;
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration on magnitudes.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] opnd_i,
    input  logic [XLEN-1:0] sr_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] sr_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;

    // Multiply: conditional add then 64-bit right shift keeping carry.
    // Divide: shift in dividend MSB, trial subtract, restore on borrow.
    always_comb begin
        acc_o  = acc_i;
        sr_o   = sr_i;
        sum    = '0;
        rem_sh = '0;
        if (is_div) begin
            rem_sh = {acc_i, sr_i[XLEN-1]};
            if (rem_sh >= {1'b0, opnd_i}) begin
                acc_o = XLEN'(rem_sh - {1'b0, opnd_i});
                sr_o  = {sr_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = rem_sh[XLEN-1:0];
                sr_o  = {sr_i[XLEN-2:0], 1'b0};
            end
        end else begin
            sum   = {1'b0, acc_i} + (sr_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
            acc_o = sum[XLEN:1];
            sr_o  = {sum[0], sr_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: stalls the pipe, iterates, then writes HI/LO once.
// Latency: 34 cycles start-to-strobe (MULDIV_FAST_MUL_EN: multiplies take 2).
// Backpressure: stall is held from accept until the DONE cycle; flush cancels.
import muldiv_pkg::*;

module muldiv_ctrl #(
    parameter int XLEN = 32,
    parameter int ITER = MULDIV_ITER
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            hilo_wen,
    output logic [XLEN-1:0] hi_wdata,
    output logic [XLEN-1:0] lo_wdata
);

    localparam int          CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            sign_a_q, sign_a_d;
    logic            neg_res_q, neg_res_d;
    logic            div0_q, div0_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] sr_q, sr_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    op_e             opc;
    logic            signed_op;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] acc_nx, sr_nx;
    logic [2*XLEN-1:0] prod_mag, prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] prod_fast;
`endif

    assign opc = op_e'(op);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (is_div_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .sr_i   (sr_q),
        .acc_o  (acc_nx),
        .sr_o   (sr_nx)
    );

    // Next-state, operand latching, iteration and final sign fix-up
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        sign_a_d  = sign_a_q;
        neg_res_d = neg_res_q;
        div0_d    = div0_q;
        acc_d     = acc_q;
        sr_d      = sr_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        signed_op = (opc == OP_MULT) || (opc == OP_DIV);
        a_mag     = (signed_op && a[XLEN-1]) ? -a : a;
        b_mag     = (signed_op && b[XLEN-1]) ? -b : b;
`ifdef MULDIV_FAST_MUL_EN
        // Sign-extend per op; the low 2*XLEN bits are correct either way
        prod_fast = {{XLEN{signed_op & a[XLEN-1]}}, a} * {{XLEN{signed_op & b[XLEN-1]}}, b};
`endif

        // Results of the final step, with signs restored
        prod_mag = {acc_nx, sr_nx};
        prod_fix = neg_res_q ? -prod_mag : prod_mag;
        quot_fix = div0_q ? DIV0_QUOT : (neg_res_q ? -sr_nx : sr_nx);
        rem_fix  = sign_a_q ? -acc_nx : acc_nx;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_div_d  = (opc == OP_DIV) || (opc == OP_DIVU);
                    sign_a_d  = signed_op & a[XLEN-1];
                    neg_res_d = signed_op & (a[XLEN-1] ^ b[XLEN-1]);
                    div0_d    = (b == '0);
                    cnt_d     = '0;
                    acc_d     = '0;
                    sr_d      = a_mag;
                    opnd_d    = b_mag;
                    state_d   = ST_BUSY;
`ifdef MULDIV_FAST_MUL_EN
                    if (!((opc == OP_DIV) || (opc == OP_DIVU))) begin
                        hi_d    = prod_fast[2*XLEN-1:XLEN];
                        lo_d    = prod_fast[XLEN-1:0];
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_BUSY: begin
                acc_d = acc_nx;
                sr_d  = sr_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    hi_d    = is_div_q ? rem_fix  : prod_fix[2*XLEN-1:XLEN];
                    lo_d    = is_div_q ? quot_fix : prod_fix[XLEN-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A cancelled instruction must leave HI/LO outputs untouched
        if (flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            neg_res_q <= 1'b0;
            div0_q    <= 1'b0;
            acc_q     <= '0;
            sr_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            sign_a_q  <= sign_a_d;
            neg_res_q <= neg_res_d;
            div0_q    <= div0_d;
            acc_q     <= acc_d;
            sr_q      <= sr_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign stall    = !flush && (((state_q == ST_IDLE) && start) || (state_q == ST_BUSY));
    assign busy     = (state_q != ST_IDLE);
    assign hilo_wen = (state_q == ST_DONE) && !flush;
    assign hi_wdata = hi_q;
    assign lo_wdata = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed table, randomized ops vs arithmetic model,
// and hand sequences for flush, reset, held start and start+flush.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_muldiv_ctrl;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, hilo_wen;
    logic [31:0] hi_wdata, lo_wdata;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    muldiv_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .hilo_wen (hilo_wen),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (hilo_wen) wen_cnt++;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin p = sx * sy; return p; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; return p; end
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Entered just after a posedge; runs one op from its cycle 0 to its DONE cycle
    task automatic do_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] ehi, input logic [31:0] elo, input string nm);
        int lat;
        int exp_lat;
        bit stall_ok;
        logic [31:0] ghi, glo;
        exp_lat = (FAST && !o[1]) ? 1 : 33;
        lat = 0;
        stall_ok = 1'b1;
        ghi = '0;
        glo = '0;
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        chk({nm, "_busy_c0"}, 64'(busy), 64'd0);
        chk({nm, "_stall_c0"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (hilo_wen) begin
                lat = k;
                ghi = hi_wdata;
                glo = lo_wdata;
                if (stall) stall_ok = 1'b0;
                break;
            end
            if (!stall) stall_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_stall"}, 64'(stall_ok), 64'd1);
        chk({nm, "_hi"}, 64'(ghi), 64'(ehi));
        chk({nm, "_lo"}, 64'(glo), 64'(elo));
        last_hi = ehi;
        last_lo = elo;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [63:0] e;
        int w0;
        logic [1:0] rop;

        tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        tbl[4] = '{2'b11, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        tbl[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        tbl[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[8] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[9] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wen", 64'(hilo_wen), 64'd0);
        chk("rst_hi", 64'(hi_wdata), 64'd0);
        chk("rst_lo", 64'(lo_wdata), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed vectors; results must hold in the following cycle
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_hold_hi", i), 64'(hi_wdata), 64'(tbl[i].hi));
            chk($sformatf("vec%0d_hold_lo", i), 64'(lo_wdata), 64'(tbl[i].lo));
            @(posedge clk); #1;
        end

        // Randomized back-to-back ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 20));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            e = ref_model(ro, ra, rb);
            do_op(ro, ra, rb, e[63:32], e[31:0], $sformatf("rnd%0d", i));
        end

        // Flush in cycle 10 of a DIV, new start accepted in cycle 11
        w0 = wen_cnt;
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 64'(stall), 64'd0);
        chk("flush_wen", 64'(hilo_wen), 64'd0);
        chk("flush_hi_kept", 64'(hi_wdata), 64'(last_hi));
        chk("flush_lo_kept", 64'(lo_wdata), 64'(last_lo));
        @(posedge clk); #1;
        flush = 1'b0;
        e = ref_model(2'b11, 32'd100, 32'd7);
        do_op(2'b11, 32'd100, 32'd7, e[63:32], e[31:0], "after_flush");
        chk("flush_wen_count", 64'(wen_cnt - w0), 64'd1);

        // Reset in cycle 20 overrides a held start and aborts with no write
        w0 = wen_cnt;
        rop = FAST ? 2'b10 : 2'b00;
        start = 1'b1; op = rop; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", 64'(stall), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_wen", 64'(hilo_wen), 64'd0);
        chk("rst_mid_hi", 64'(hi_wdata), 64'd0);
        chk("rst_mid_lo", 64'(lo_wdata), 64'd0);
        chk("rst_mid_nowrite", 64'(wen_cnt - w0), 64'd0);
        @(posedge clk); #1;

        // Start held high: DONE ignores it, one write per 34 cycles
        w0 = wen_cnt;
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        repeat (102) @(posedge clk);
        #1;
        start = 1'b0;
        chk("held_start_writes", 64'(wen_cnt - w0), 64'd3);
        @(negedge clk);
        chk("held_start_hi", 64'(hi_wdata), 64'h2);
        chk("held_start_lo", 64'(lo_wdata), 64'hE);
        chk("held_start_idle", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Start and flush together in IDLE: nothing starts
        w0 = wen_cnt;
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(negedge clk);
        chk("sf_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("sf_busy", 64'(busy), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("sf_nowrite", 64'(wen_cnt - w0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the EX-stage multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU when they reach EX and runs an iterative 32-step shift-add or restoring-divide datapath. While the operation runs it holds the pipeline with a stall. When the operation finishes it issues one HI/LO write strobe with both result words into the hilo register block.

## Interface
Parameters:
- `XLEN`, 32, operand and result word width; only 32 is supported.
- `ITER`, 32, number of iteration steps; must equal XLEN.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  a valid mul/div instruction is in EX with operands valid (forwarded values).
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  XLEN  GPR[rs], forwarded.
- `b`  in  XLEN  GPR[rt], forwarded.
- `flush`  in  1  exception/eret cancel of the EX instruction.
- `stall`  out  1  hold IF/ID/EX; combinational.
- `busy`  out  1  operation in flight (state != IDLE).
- `hilo_wen`  out  1  one-cycle write strobe for HI and LO together.
- `hi_wdata`  out  XLEN  HI result: product high word, or remainder.
- `lo_wdata`  out  XLEN  LO result: product low word, or quotient.

## Operation
- States and transitions:
  - IDLE: `start` && !`flush` latches `op`, |a|, |b| (signed ops only), sign flags, and clears counter and accumulators, then goes to BUSY.
  - BUSY: one step per cycle; counter counts 0..ITER-1; at ITER-1 goes to DONE.
  - DONE: computes final sign fix, drives result, goes to IDLE. `start` is ignored in DONE.
- Multiply step: if multiplier LSB is 1, add the multiplicand to the upper accumulator. Then shift the 64-bit {acc, multiplier} right 1, keeping the adder carry out.
- Divide step: shift the remainder left, bringing in the dividend MSB. Subtract the divisor. If the result is non-negative, keep it and shift quotient bit 1; otherwise restore and shift 0.
- Sign fix for signed ops:
  - Product is negated when sign(a) != sign(b).
  - Quotient is negated when signs differ.
  - Remainder takes the sign of a.
- Arithmetic: all results are mod 2^32. 0x80000000 / -1 gives LO=0x80000000, HI=0.
- Divide by zero is deterministic for both DIV and DIVU: LO=0xFFFFFFFF, HI=a (raw dividend). No exception is raised. The full 32 steps still run.
- `stall` = (IDLE && `start` && !`flush`) || BUSY, each term gated by !`flush`.
- `hilo_wen` = DONE && !`flush`.
- `hi_wdata`/`lo_wdata` are registered results. They are valid in DONE and hold their value until the next DONE.
- Flush in any state returns the block to IDLE at the next edge. No `hilo_wen` is issued for the cancelled operation. `stall` drops in the flush cycle.

## Timing
- Iterative path timeline:
  - Cycle 0: `start` seen, `stall`=1.
  - Cycles 1..32: BUSY, `stall`=1.
  - Cycle 33: DONE, `stall`=0, `hilo_wen`=1. The instruction leaves EX at the end of this cycle.
- A new `start` is accepted in cycle 34 at the earliest. Back-to-back ops have no further bubble.
- Reset values: state IDLE, counter 0, `stall`=0, `busy`=0, `hilo_wen`=0, `hi_wdata`=0, `lo_wdata`=0.
- Reset asserted mid-operation aborts the operation with no write. It overrides `flush` and `start`.
- Simultaneous `start` and `flush` in IDLE: no operation starts.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle XLEN×XLEN multiplier and go IDLE→DONE.
  - Timeline is cycle 0 `stall`=1, cycle 1 `hilo_wen`=1.
  - Division is unchanged at 34 cycles.
- Not defined: multiply uses the iterative shift-add path with 34-cycle total latency. No hardware multiplier is inferred.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state enum: ST_IDLE, ST_BUSY, ST_DONE.
  - constants: MULDIV_ITER=32, DIV0_QUOT=32'hFFFFFFFF.
- One sub-module `muldiv_step`: a combinational single iteration that takes op class, accumulator, operand and shift registers and returns the next values. It is instantiated once.
- The top holds the FSM, counter, operand latches and sign fix.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → `stall` high for cycles 0–32, cycle 33 `hilo_wen`=1, HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. With `MULDIV_FAST_MUL_EN`, the same values arrive with `hilo_wen` at cycle 1.
- DIV a=0xFFFFFFF9 (-7) b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100 b=7 → LO=0x0000000E, HI=0x00000002.
- DIVU a=5 b=0 and DIV a=0x80000000 b=0xFFFFFFFF:
  - DIVU result: LO=0xFFFFFFFF, HI=5.
  - DIV result: LO=0x80000000, HI=0.
- `flush` asserted in cycle 10 of a DIV:
  - `stall`=0 in cycle 10, IDLE at cycle 11, no `hilo_wen`, HI/LO outputs unchanged.
  - A new `start` in cycle 11 is accepted.
- `reset` in cycle 20 of a MULT → all outputs 0 the next cycle, no write. `start` held high continuously makes exactly one write per 34 cycles (DONE ignores `start`).
